// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer letting a fetch port (m0) and a load/store port (m1) share one byte RAM.
// Define RAM_ARB_ALIGN_CHECK_EN to reject misaligned or out-of-bounds commands with err.
module ram_port_arbiter #(
    parameter int W = 32,
    parameter int L = 64,
    localparam int AW = $clog2(L * (W / 8)),
    localparam int NB = L * (W / 8)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [1:0]    m0_size,
    input  logic [AW-1:0] m0_addr,
    input  logic [W-1:0]  m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [1:0]    m1_size,
    input  logic [AW-1:0] m1_addr,
    input  logic [W-1:0]  m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [W-1:0]  rdata,
    output logic [AW-1:0] ram_addr,
    output logic [W-1:0]  ram_data_in,
    output logic [1:0]    ram_w_mode,
    output logic          ram_oe,
    input  logic [W-1:0]  ram_data_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]    state;
    logic          gnt;
    logic          last;
    logic          cmd_we;
    logic [1:0]    cmd_size;
    logic [AW-1:0] cmd_addr;
    logic [W-1:0]  cmd_wdata;
    logic          cmd_bad;

    logic          any_req;
    logic          pick;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [W-1:0]  sel_wdata;
    logic          sel_bad;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd0) ? 2'd3 : size;
    endfunction

`ifdef RAM_ARB_ALIGN_CHECK_EN
    // Reads always fetch a full word, so bounds use 4 bytes regardless of size.
    function automatic logic access_bad(input logic we, input logic [1:0] size,
                                        input logic [AW-1:0] addr);
        logic [AW:0] nbytes;
        logic        misaligned;
        if (!we || size == 2'd3)
            nbytes = (AW+1)'(4);
        else if (size == 2'd2)
            nbytes = (AW+1)'(2);
        else
            nbytes = (AW+1)'(1);
        misaligned = (size == 2'd2 && addr[0]) || (size == 2'd3 && addr[1:0] != 2'd0);
        return misaligned || (({1'b0, addr} + nbytes) > (AW+1)'(NB));
    endfunction
`endif

    always_comb begin
        any_req   = m0_req | m1_req;
        pick      = (m0_req & m1_req) ? ~last : m1_req;
        sel_we    = pick ? m1_we : m0_we;
        sel_size  = norm_size(pick ? m1_size : m0_size);
        sel_addr  = pick ? m1_addr : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
`ifdef RAM_ARB_ALIGN_CHECK_EN
        sel_bad   = access_bad(sel_we, sel_size, sel_addr);
`else
        sel_bad   = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            cmd_we    <= 1'b0;
            cmd_size  <= 2'd0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_bad   <= 1'b0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick;
                        last      <= pick;
                        cmd_we    <= sel_we;
                        cmd_size  <= sel_size;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        cmd_bad   <= sel_bad;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (!cmd_we && !cmd_bad)
                        rdata <= ram_data_out;
                    state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM and handshake outputs decode registered state only.
    always_comb begin
        ram_addr    = cmd_addr;
        ram_data_in = cmd_wdata;
        ram_w_mode  = 2'd0;
        ram_oe      = 1'b0;
        if (state == SERVE && !cmd_bad) begin
            if (cmd_we)
                ram_w_mode = cmd_size;
            else
                ram_oe = 1'b1;
        end
        m0_ack = (state == ACK) && !gnt;
        m1_ack = (state == ACK) && gnt;
        m0_err = m0_ack && cmd_bad;
        m1_err = m1_ack && cmd_bad;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a byte-addressable RAM model (256 bytes, index wrap).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [1:0]  m0_size, m1_size;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data_in;
    logic [1:0]  ram_w_mode;
    logic        ram_oe;
    logic [31:0] ram_data_out;

    logic [7:0]  mem [0:255];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.W(32), .L(64)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_w_mode(ram_w_mode), .ram_oe(ram_oe), .ram_data_out(ram_data_out)
    );

    // RAM model: little-endian, write commits on the clock edge.
    assign ram_data_out = ram_oe ? {mem[ram_addr + 8'd3], mem[ram_addr + 8'd2],
                                    mem[ram_addr + 8'd1], mem[ram_addr]} : 32'h0;

    always @(posedge clk) begin
        case (ram_w_mode)
            2'd1: mem[ram_addr] <= ram_data_in[7:0];
            2'd2: begin
                mem[ram_addr]        <= ram_data_in[7:0];
                mem[ram_addr + 8'd1] <= ram_data_in[15:8];
            end
            2'd3: begin
                mem[ram_addr]        <= ram_data_in[7:0];
                mem[ram_addr + 8'd1] <= ram_data_in[15:8];
                mem[ram_addr + 8'd2] <= ram_data_in[23:16];
                mem[ram_addr + 8'd3] <= ram_data_in[31:24];
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] memword(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    // One access on port p; lat = edges from IDLE sample to ack, -1 on timeout.
    task automatic access(input bit p, input logic we, input logic [1:0] size,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic err);
        @(negedge clk);
        if (!p) begin
            m0_req = 1'b1; m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (p ? m1_ack : m0_ack) begin
                lat = i;
                break;
            end
        end
        rd  = rdata;
        err = p ? m1_err : m0_err;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin
            errors++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err});
        end
        checks++;
        if ({ram_w_mode, ram_oe} !== 3'b000) begin
            errors++; $display("FAIL reset_ram_ctrl: got %b expected 000", {ram_w_mode, ram_oe});
        end
        checks++;
        if (rdata !== 32'h0 || ram_addr !== 8'h0 || ram_data_in !== 32'h0) begin
            errors++; $display("FAIL reset_data: rdata %h addr %h din %h expected all 0", rdata, ram_addr, ram_data_in);
        end
        reset = 1'b0;
    endtask

    task automatic test_word_rw();
        int lat; logic [31:0] rd; logic err;
        access(0, 1'b1, 2'd3, 8'h10, 32'hDEADBEEF, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0) begin
            errors++; $display("FAIL m0_write_ack: lat %0d err %b expected lat 2 err 0", lat, err);
        end
        checks++;
        if (memword(8'h10) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL m0_write_mem: got %h expected deadbeef", memword(8'h10));
        end
        access(0, 1'b0, 2'd3, 8'h10, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL m0_read: lat %0d err %b rdata %h expected 2 0 deadbeef", lat, err, rd);
        end
    endtask

    task automatic test_byte_merge();
        int lat; logic [31:0] rd; logic err;
        access(1, 1'b1, 2'd1, 8'h11, 32'h777777AA, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL m1_byte_write: lat %0d err %b rdata %h expected 2 0 deadbeef(held)", lat, err, rd);
        end
        access(1, 1'b0, 2'd1, 8'h10, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADAAEF) begin
            errors++; $display("FAIL m1_byte_read: lat %0d rdata %h expected 2 deadaaef", lat, rd);
        end
        access(1, 1'b1, 2'd0, 8'h30, 32'hCAFEF00D, lat, rd, err);
        checks++;
        if (memword(8'h30) !== 32'hCAFEF00D || err !== 1'b0) begin
            errors++; $display("FAIL size0_word: mem %h err %b expected cafef00d 0", memword(8'h30), err);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int cyc = 0;
        bit both = 1'b0;
        bit who [4];
        int when [4];
        logic [31:0] rds [4];
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_size = 2'd3; m0_addr = 8'h10;
        m1_req = 1; m1_we = 0; m1_size = 2'd3; m1_addr = 8'h30;
        while (n < 4 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (m0_ack && m1_ack) both = 1'b1;
            if (m0_ack || m1_ack) begin
                who[n] = m1_ack; when[n] = cyc; rds[n] = rdata;
                n++;
                if (n == 4) begin m0_req = 0; m1_req = 0; end
            end
        end
        m0_req = 0; m1_req = 0;
        @(posedge clk);
        checks++;
        if (n !== 4 || both !== 1'b0) begin
            errors++; $display("FAIL rr_count: acks %0d both %b expected 4 0", n, both);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (who[k] !== k[0] || when[k] !== 2 + 3 * k ||
                rds[k] !== (k[0] ? 32'hCAFEF00D : 32'hDEADAAEF)) begin
                errors++; $display("FAIL rr_grant%0d: port %0d cycle %0d rdata %h expected port %0d cycle %0d",
                                   k, who[k], when[k], rds[k], k[0], 2 + 3 * k);
            end
        end
    endtask

    task automatic test_align();
        int lat; logic [31:0] rd; logic err;
        access(0, 1'b1, 2'd3, 8'h20, 32'h11223344, lat, rd, err);
        access(1, 1'b1, 2'd3, 8'hFC, 32'hA5A55A5A, lat, rd, err);
        access(0, 1'b1, 2'd2, 8'h21, 32'h0000BEEF, lat, rd, err);
`ifdef RAM_ARB_ALIGN_CHECK_EN
        checks++;
        if (lat !== 2 || err !== 1'b1 || memword(8'h20) !== 32'h11223344) begin
            errors++; $display("FAIL half_misaligned: lat %0d err %b mem %h expected 2 1 11223344", lat, err, memword(8'h20));
        end
`else
        checks++;
        if (lat !== 2 || err !== 1'b0 || memword(8'h20) !== 32'h11BEEF44) begin
            errors++; $display("FAIL half_unaligned: lat %0d err %b mem %h expected 2 0 11beef44", lat, err, memword(8'h20));
        end
`endif
        access(0, 1'b0, 2'd3, 8'hFC, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hA5A55A5A) begin
            errors++; $display("FAIL read_top_word: lat %0d err %b rdata %h expected 2 0 a5a55a5a", lat, err, rd);
        end
        access(1, 1'b0, 2'd2, 8'hFE, 32'h0, lat, rd, err);
`ifdef RAM_ARB_ALIGN_CHECK_EN
        checks++;
        if (err !== 1'b1 || rd !== 32'hA5A55A5A) begin
            errors++; $display("FAIL read_oob: err %b rdata %h expected 1 a5a55a5a(held)", err, rd);
        end
`else
        checks++;
        if (err !== 1'b0 || rd !== 32'h0000A5A5) begin
            errors++; $display("FAIL read_wrap: err %b rdata %h expected 0 0000a5a5", err, rd);
        end
`endif
    endtask

    task automatic test_reset_in_serve();
        int lat; logic [31:0] rd; logic err;
        bit seen = 1'b0;
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_size = 2'd3; m1_addr = 8'h40; m1_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        checks++;
        if (ram_w_mode !== 2'd3 || ram_addr !== 8'h40) begin
            errors++; $display("FAIL serve_drive: w_mode %0d addr %h expected 3 40", ram_w_mode, ram_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m1_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (m0_ack || m1_ack) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0 || memword(8'h40) !== 32'h12345678) begin
            errors++; $display("FAIL reset_serve: ack_seen %b mem %h expected 0 12345678", seen, memword(8'h40));
        end
        access(0, 1'b0, 2'd3, 8'h40, 32'h0, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h12345678) begin
            errors++; $display("FAIL after_reset_read: lat %0d err %b rdata %h expected 2 0 12345678", lat, err, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_round_robin();
        test_align();
        test_reset_in_serve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer in front of the byte-addressable `ram` (W=32, L=64). It lets a fetch port (m0) and a load/store port (m1) share the single RAM port, with round-robin fairness and a req/ack handshake. It drives the RAM's `addr`/`data_in`/`w_mode`/`oe`, registers read data, and returns a one-cycle ack per access. Misalignment and bounds checking can optionally be compiled in.

## Interface
Parameters:
- `W`, 32: data width; only 32 is supported (RAM packs 4 bytes).
- `L`, 64: RAM depth in words. Localparam `AW = $clog2(L*(W/8))` (8 at defaults). Localparam `NB = L*(W/8)` (256 bytes).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m0_req`, `m1_req` in 1: access request, level; held until the matching ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_size`, `m1_size` in 2: 1 = byte, 2 = half, 3 = word; 0 is treated as 3.
- `m0_addr`, `m1_addr` in AW: byte address.
- `m0_wdata`, `m1_wdata` in W: write data; byte in [7:0], half in [15:0].
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = access rejected, RAM untouched.
- `rdata` out W: read data, valid in the ack cycle of a read; holds its value otherwise.
- `ram_addr` out AW, `ram_data_in` out W, `ram_w_mode` out 2, `ram_oe` out 1: drive the RAM.
- `ram_data_out` in W: RAM read data (combinational from the RAM).

## Operation
- FSM states: IDLE, SERVE, ACK. A registered `gnt` (0/1) selects the served port. A registered `last` records the last port granted.
- IDLE:
  - If no req: stay in IDLE.
  - If exactly one req: grant that port.
  - If both req: grant `!last`.
  - On a grant: latch the port's we/size/addr/wdata into a command register, set `gnt`, update `last`, go to SERVE.
- SERVE (exactly one cycle):
  - Drive `ram_addr` from the command address.
  - Write: `ram_w_mode` = size, `ram_oe` = 0.
  - Read: `ram_w_mode` = 0, `ram_oe` = 1. Capture `ram_data_out` into `rdata` at the end of the cycle.
  - Go to ACK.
- ACK (one cycle):
  - Pulse `m<gnt>_ack`; drive `m<gnt>_err`.
  - Next state is always IDLE. The requester must drop req in the ACK cycle; a req still high in IDLE is taken as a new access.
- Outside SERVE: `ram_w_mode` = 0, `ram_oe` = 0, `ram_addr` = command address, `ram_data_in` = command wdata. All RAM-side outputs are decoded only from registered state.
- Reads always return the full 32-bit little-endian word at addr. Size is used only by the checker.
- Reset values:
  - State IDLE, `last` = 1 (m0 wins the first tie), `gnt` = 0.
  - `rdata` = 0, command register = 0.
  - All acks and errs 0.
  - `ram_w_mode` = 0, `ram_oe` = 0.

## Timing
- Access latency: req sampled high in IDLE at edge n; SERVE during cycle n+1; ack high during cycle n+2.
- Throughput: one access per 3 cycles.
- Both ports requesting continuously: grants alternate m0, m1, m0, …
- RAM write commits at the rising edge that ends SERVE.
- Reset mid-operation:
  - Reset high at the edge ending SERVE: the RAM write still commits (RAM sees SERVE-cycle outputs), but no ack is issued and state returns to IDLE.
  - Reset high in ACK: ack is still visible in that cycle; state then returns to IDLE.
- A req change in SERVE or ACK has no effect on the current access.

## Configuration
- `RAM_ARB_ALIGN_CHECK_EN` defined:
  - In IDLE, at grant, the command is flagged bad if it is misaligned or out of bounds.
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - Out of bounds: addr + nbytes > NB, where nbytes = 1/2/4. A read uses nbytes = 4.
  - A flagged command still passes SERVE with `ram_w_mode` = 0 and `ram_oe` = 0. ACK has err = 1 and `rdata` is unchanged.
- Undefined: every command passes straight through, err is tied 0, and the RAM's own index wrap applies.

## Test plan
- Reset, then m0 writes word 0xDEADBEEF at 0x10, then m0 reads 0x10.
  - Required: each ack at cycle +2 after req; rdata = 0xDEADBEEF; err = 0.
- m1 writes byte 0xAA to 0x11 over the word above, then reads 0x10.
  - Required: rdata = 0xDEADAAEF.
- m0 and m1 both hold req for 4 accesses.
  - Required: ack order m0, m1, m0, m1; no cycle with both acks high.
- m0 issues a half write to 0x21, then a word read at 0xFC.
  - With the macro: first access err = 1 and the RAM is unchanged at 0x20–0x23; second access err = 0.
  - Without the macro: the half write lands at 0x21–0x22 with err = 0.
- m1 word write of 0x12345678 at 0x40, with reset asserted in its SERVE cycle.
  - Required: no ack; bytes 0x40–0x43 hold 0x12345678; the next m0 req is served normally.
